// File: rtl/cpu_pkg.sv
// cpu_pkg - shared definitions for the 8-bit CPU sequencing control unit.
//   * opcode encodings (ALU ops 0x0-0xB, then LDI/JMP/NOP/HALT)
//   * control FSM state encoding
//   * instruction field bit positions
//   * data / instruction widths
package cpu_pkg;

  localparam int LARG_DADO  = 8;
  localparam int LARG_INSTR = 16;
  localparam int NUM_REGS   = 4;

  // Instruction fields: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 10;
  localparam int RS_MSB  = 9;
  localparam int RS_LSB  = 8;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  localparam logic [3:0] OP_ZERO  = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_MUL   = 4'h3;
  localparam logic [3:0] OP_DIV   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_NOTA  = 4'h7;
  localparam logic [3:0] OP_XOR   = 4'h8;
  localparam logic [3:0] OP_XNOR  = 4'h9;
  localparam logic [3:0] OP_PASSA = 4'hA;
  localparam logic [3:0] OP_NOTA2 = 4'hB;
  localparam logic [3:0] OP_LDI   = 4'hC;
  localparam logic [3:0] OP_JMP   = 4'hD;
  localparam logic [3:0] OP_NOP   = 4'hE;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    INICIO  = 3'd0,
    BUSCA   = 3'd1,
    DECOD   = 3'd2,
    EXEC    = 3'd3,
    ESCRITA = 3'd4,
    PARADO  = 3'd5
  } estado_t;

  // Everything below LDI goes straight to the ALU.
  function automatic logic eh_ula(input logic [3:0] op);
    return (op <= OP_NOTA2);
  endfunction

endpackage

// File: rtl/banco_registradores.sv
// banco_registradores - 4 x 8-bit register file.
//   clk, rst_n      : clock, asynchronous active-low reset (all registers -> 0)
//   we, sel_w, dado_w : single write port
//   sel_a / dado_a  : read port (rd operand)
//   sel_b / dado_b  : read port (rs operand)
//   dbg_sel / dbg_dado : debug read port
// All reads are combinational.
module banco_registradores
  import cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [1:0]           sel_w,
  input  logic [LARG_DADO-1:0] dado_w,
  input  logic [1:0]           sel_a,
  output logic [LARG_DADO-1:0] dado_a,
  input  logic [1:0]           sel_b,
  output logic [LARG_DADO-1:0] dado_b,
  input  logic [1:0]           dbg_sel,
  output logic [LARG_DADO-1:0] dbg_dado
);

  logic [NUM_REGS-1:0][LARG_DADO-1:0] regs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) regs <= '0;
    else if (we) regs[sel_w] <= dado_w;
  end

  assign dado_a   = regs[sel_a];
  assign dado_b   = regs[sel_b];
  assign dbg_dado = regs[dbg_sel];

endmodule

// File: rtl/unidade_controle.sv
// unidade_controle - sequencing control unit of the 8-bit CPU.
// Fetches 16-bit instructions over a req/ack handshake, decodes them, drives
// the external ALU operands/opcode and writes results back to a 4x8 register
// file.
//   clk, rst_n            : clock, asynchronous active-low reset
//   instr_req/instr_addr  : fetch request (held until ack) and address (= pc)
//   instr_ack/instr_dado  : memory acknowledge, instruction valid with ack
//   ula_a/ula_b/ula_opcode: registered ALU inputs
//   ula_saida             : combinational ALU result
//   parado                : high after HALT
//   erro_div              : sticky division-by-zero flag
//   dbg_sel/dbg_dado      : register-file debug read
module unidade_controle
  import cpu_pkg::*;
#(
  parameter int LARG_PC = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  instr_req,
  output logic [LARG_PC-1:0]    instr_addr,
  input  logic                  instr_ack,
  input  logic [LARG_INSTR-1:0] instr_dado,
  output logic [LARG_DADO-1:0]  ula_a,
  output logic [LARG_DADO-1:0]  ula_b,
  output logic [3:0]            ula_opcode,
  input  logic [LARG_DADO-1:0]  ula_saida,
  output logic                  parado,
  output logic                  erro_div,
  input  logic [1:0]            dbg_sel,
  output logic [LARG_DADO-1:0]  dbg_dado
);

  estado_t               estado;
  logic [LARG_PC-1:0]    pc;
  logic [LARG_INSTR-1:0] ir;
  logic [LARG_DADO-1:0]  resultado;

  logic [3:0]           op;
  logic [1:0]           rd, rs;
  logic [LARG_DADO-1:0] imm;
  logic [LARG_DADO-1:0] dado_rd, dado_rs;
  logic                 we;
  logic [LARG_DADO-1:0] dado_w;

  assign op  = ir[OP_MSB:OP_LSB];
  assign rd  = ir[RD_MSB:RD_LSB];
  assign rs  = ir[RS_MSB:RS_LSB];
  assign imm = ir[IMM_MSB:IMM_LSB];

  assign instr_addr = pc;

  // Write-back happens only in ESCRITA; NOP passes through ESCRITA for the
  // pc update but must not touch the register file.
  assign we     = (estado == ESCRITA) && (eh_ula(op) || op == OP_LDI);
  assign dado_w = (op == OP_LDI) ? imm : resultado;

  banco_registradores u_banco (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (we),
    .sel_w    (rd),
    .dado_w   (dado_w),
    .sel_a    (rd),
    .dado_a   (dado_rd),
    .sel_b    (rs),
    .dado_b   (dado_rs),
    .dbg_sel  (dbg_sel),
    .dbg_dado (dbg_dado)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado     <= INICIO;
      pc         <= '0;
      ir         <= '0;
      resultado  <= '0;
      ula_a      <= '0;
      ula_b      <= '0;
      ula_opcode <= '0;
      instr_req  <= 1'b0;
      parado     <= 1'b0;
      erro_div   <= 1'b0;
    end else begin
      case (estado)
        INICIO: begin
          instr_req <= 1'b1;
          estado    <= BUSCA;
        end
        BUSCA: begin
          if (instr_ack) begin
            ir        <= instr_dado;
            instr_req <= 1'b0;
            estado    <= DECOD;
          end
        end
        DECOD: begin
          if (eh_ula(op)) begin
            ula_a      <= dado_rd;
            ula_b      <= dado_rs;
            ula_opcode <= op;
            estado     <= EXEC;
          end else begin
            case (op)
              OP_JMP: begin
                pc        <= LARG_PC'(imm);
                instr_req <= 1'b1;
                estado    <= BUSCA;
              end
              OP_HALT: begin
                parado <= 1'b1;
                estado <= PARADO;
              end
              default: estado <= ESCRITA;  // LDI, NOP
            endcase
          end
        end
        EXEC: begin
          // ula_b holds R[rs], so it is the divisor for OP_DIV.
          if (ula_opcode == OP_DIV && ula_b == '0) begin
            resultado <= '1;
            erro_div  <= 1'b1;
          end else begin
            resultado <= ula_saida;
          end
          estado <= ESCRITA;
        end
        ESCRITA: begin
          pc        <= pc + LARG_PC'(1);
          instr_req <= 1'b1;
          estado    <= BUSCA;
        end
        PARADO: estado <= PARADO;
        default: begin
          instr_req <= 1'b0;
          estado    <= INICIO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle - directed self-checking bench for unidade_controle.
// Provides an ALU model, an instruction memory with configurable ack delay,
// and a linear sequence of directed programs with hand-computed results.
module tb_unidade_controle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_req;
  logic [7:0]  instr_addr;
  logic        instr_ack = 1'b0;
  logic [15:0] instr_dado = 16'h0;
  logic [7:0]  ula_a, ula_b, ula_saida;
  logic [3:0]  ula_opcode;
  logic        parado, erro_div;
  logic [1:0]  dbg_sel = 2'd0;
  logic [7:0]  dbg_dado;

  logic [15:0] mem [0:255];
  int          wait_n = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        busy = 1'b0;
  logic [7:0]  hold_addr = 8'h0;
  int          wcnt = 0;

  always #5 clk = ~clk;

  unidade_controle #(.LARG_PC(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_req  (instr_req),
    .instr_addr (instr_addr),
    .instr_ack  (instr_ack),
    .instr_dado (instr_dado),
    .ula_a      (ula_a),
    .ula_b      (ula_b),
    .ula_opcode (ula_opcode),
    .ula_saida  (ula_saida),
    .parado     (parado),
    .erro_div   (erro_div),
    .dbg_sel    (dbg_sel),
    .dbg_dado   (dbg_dado)
  );

  // ALU model (lives outside the control unit in the real CPU)
  always_comb begin
    ula_saida = 8'h00;
    case (ula_opcode)
      4'h0: ula_saida = 8'h00;
      4'h1: ula_saida = ula_a + ula_b;
      4'h2: ula_saida = ula_a - ula_b;
      4'h3: ula_saida = 8'(ula_a * ula_b);
      4'h4: ula_saida = (ula_b == 8'h00) ? 8'h00 : ula_a / ula_b;
      4'h5: ula_saida = ula_a & ula_b;
      4'h6: ula_saida = ula_a | ula_b;
      4'h7: ula_saida = ~ula_a;
      4'h8: ula_saida = ula_a ^ ula_b;
      4'h9: ula_saida = ~(ula_a ^ ula_b);
      4'hA: ula_saida = ula_a;
      4'hB: ula_saida = ~ula_a;
      default: ula_saida = 8'h00;
    endcase
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after wait_n request cycles, checks that the
  // fetch address holds still while the request is pending.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 1'b0; wcnt = 0; instr_ack = 1'b0;
    end else if (instr_req) begin
      if (!busy) begin
        busy = 1'b1; hold_addr = instr_addr; wcnt = 0;
      end else begin
        chk("addr_stable", {8'h0, instr_addr}, {8'h0, hold_addr});
      end
      if (wcnt >= wait_n) begin
        instr_ack  = 1'b1;
        instr_dado = mem[instr_addr];
        busy       = 1'b0;
      end else begin
        instr_ack = 1'b0;
        wcnt++;
      end
    end else begin
      instr_ack = 1'b0;
      busy      = 1'b0;
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  task automatic prog_basic();
    clear_mem();
    mem[0] = 16'hC005;  // LDI R0,5
    mem[1] = 16'hC403;  // LDI R1,3
    mem[2] = 16'h1100;  // ADD R0,R1
    mem[3] = 16'hF000;  // HALT
  endtask

  task automatic start();
    @(negedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic rreg(input string tag, input int i, input logic [7:0] exp);
    dbg_sel = 2'(i); #1;
    chk(tag, {8'h0, dbg_dado}, {8'h0, exp});
  endtask

  task automatic wait_halt(input int budget);
    int c;
    c = 0;
    while (parado !== 1'b1 && c < budget) begin
      @(posedge clk); #1; c++;
    end
    chk("halt_reached", {15'h0, parado}, 16'h1);
  endtask

  initial begin
    // ---- reset state ----
    prog_basic();
    @(negedge clk);
    chk("rst_req",    {15'h0, instr_req}, 16'h0);
    chk("rst_parado", {15'h0, parado},    16'h0);
    chk("rst_errdiv", {15'h0, erro_div},  16'h0);
    chk("rst_ula_a",  {8'h0, ula_a},      16'h0);
    chk("rst_ula_b",  {8'h0, ula_b},      16'h0);
    chk("rst_opc",    {12'h0, ula_opcode}, 16'h0);
    chk("rst_addr",   {8'h0, instr_addr}, 16'h0);
    for (int i = 0; i < 4; i++) rreg("rst_reg", i, 8'h00);

    // ---- basic program, zero wait: 13 cycles to PARADO ----
    start();
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      if (c == 1) chk("req_first", {15'h0, instr_req}, 16'h1);
      if (c == 9) begin
        chk("exec_opc", {12'h0, ula_opcode}, 16'h1);
        chk("exec_a",   {8'h0, ula_a},       16'h5);
        chk("exec_b",   {8'h0, ula_b},       16'h3);
      end
      if (c == 12) chk("parado_c12", {15'h0, parado}, 16'h0);
      if (c == 13) chk("parado_c13", {15'h0, parado}, 16'h1);
    end
    rreg("add_r0", 0, 8'h08);
    rreg("add_r1", 1, 8'h03);

    // ---- same program, 3 wait cycles per fetch: 25 cycles ----
    rst_n = 1'b0; wait_n = 3;
    start();
    for (int c = 1; c <= 25; c++) begin
      @(posedge clk); #1;
      if (c == 24) chk("wait_parado_c24", {15'h0, parado}, 16'h0);
      if (c == 25) chk("wait_parado_c25", {15'h0, parado}, 16'h1);
    end
    rreg("wait_r0", 0, 8'h08);
    rreg("wait_r1", 1, 8'h03);

    // ---- division by zero ----
    rst_n = 1'b0; wait_n = 0;
    clear_mem();
    mem[0] = 16'hC807;  // LDI R2,7
    mem[1] = 16'hCC00;  // LDI R3,0
    mem[2] = 16'h4B00;  // DIV R2,R3
    mem[3] = 16'hC001;  // LDI R0,1
    mem[4] = 16'hF000;  // HALT
    start();
    wait_halt(100);
    rreg("div_r2", 2, 8'hFF);
    rreg("div_r3", 3, 8'h00);
    rreg("div_r0", 0, 8'h01);
    chk("div_errflag", {15'h0, erro_div}, 16'h1);
    rst_n = 1'b0; #1;
    chk("errdiv_cleared", {15'h0, erro_div}, 16'h0);
    chk("parado_cleared", {15'h0, parado},   16'h0);

    // ---- JMP FF, NOP at FF, pc wraps to 00 ----
    clear_mem();
    mem[0]   = 16'hD0FF;  // JMP FF
    mem[255] = 16'hE000;  // NOP
    start();
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 2) chk("jmp_req_low", {15'h0, instr_req}, 16'h0);
      if (c == 3) begin
        chk("jmp_req",  {15'h0, instr_req}, 16'h1);
        chk("jmp_addr", {8'h0, instr_addr}, 16'h00FF);
      end
      if (c == 5) chk("nop_req_low", {15'h0, instr_req}, 16'h0);
      if (c == 6) begin
        chk("wrap_req",  {15'h0, instr_req}, 16'h1);
        chk("wrap_addr", {8'h0, instr_addr}, 16'h0000);
      end
    end

    // ---- MUL truncation ----
    rst_n = 1'b0;
    clear_mem();
    mem[0] = 16'hC014;  // LDI R0,20
    mem[1] = 16'hC414;  // LDI R1,20
    mem[2] = 16'h3100;  // MUL R0,R1
    mem[3] = 16'hF000;
    start();
    wait_halt(100);
    rreg("mul_r0", 0, 8'h90);
    rreg("mul_r1", 1, 8'h14);

    // ---- reset pulse during EXEC ----
    rst_n = 1'b0;
    prog_basic();
    dbg_sel = 2'd0;
    start();
    repeat (9) @(posedge clk);
    #2;
    chk("pre_exec_opc", {12'h0, ula_opcode}, 16'h1);
    chk("pre_exec_r0",  {8'h0, dbg_dado},    16'h5);
    rst_n = 1'b0; #1;
    chk("rexec_req", {15'h0, instr_req},  16'h0);
    chk("rexec_opc", {12'h0, ula_opcode}, 16'h0);
    chk("rexec_a",   {8'h0, ula_a},       16'h0);
    chk("rexec_r0",  {8'h0, dbg_dado},    16'h0);
    rreg("rexec_r1", 1, 8'h00);
    dbg_sel = 2'd0;
    start();
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        chk("rexec_restart_req",  {15'h0, instr_req}, 16'h1);
        chk("rexec_restart_addr", {8'h0, instr_addr}, 16'h0);
      end
      if (c == 3) chk("rexec_nowrite_r0", {8'h0, dbg_dado}, 16'h0);
    end
    wait_halt(100);
    rreg("rexec_final_r0", 0, 8'h08);

    // ---- reset pulse during BUSCA (waiting on ack) ----
    rst_n = 1'b0; wait_n = 3;
    dbg_sel = 2'd0;
    start();
    repeat (14) @(posedge clk);
    #2;
    chk("pre_busca_req",  {15'h0, instr_req}, 16'h1);
    chk("pre_busca_addr", {8'h0, instr_addr}, 16'h2);
    chk("pre_busca_r0",   {8'h0, dbg_dado},   16'h5);
    rst_n = 1'b0; #1;
    chk("rbusca_req",  {15'h0, instr_req}, 16'h0);
    chk("rbusca_addr", {8'h0, instr_addr}, 16'h0);
    chk("rbusca_r0",   {8'h0, dbg_dado},   16'h0);
    start();
    @(posedge clk); #1;
    chk("rbusca_restart_req",  {15'h0, instr_req}, 16'h1);
    chk("rbusca_restart_addr", {8'h0, instr_addr}, 16'h0);
    wait_halt(200);
    rreg("rbusca_final_r0", 0, 8'h08);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
